// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_buffer_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/ifu_fetch_buffer_inst_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries; flush empties it and overrides push.
module ifu_inst_fifo
   import ifu_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_push,
   input  logic [2*XLEN-1:0]          i_push_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic [2*XLEN-1:0]          o_head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Fetch unit: owns the fetch PC, issues credit-limited imem reads and buffers in-order
// responses as {pc, inst} for the core; redirects flush and squash stale responses.
module ifu_fetch_buffer
   import ifu_fetch_buffer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_resp_valid,
   input  logic [31:0] i_imem_resp_data,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_pc,
   output logic [31:0] o_out_inst,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(DEPTH);

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_resp_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;

   logic [CNT_W-1:0]  w_occupancy;
   logic [CNT_W:0]    w_in_use;
   logic              w_full;
   logic              w_empty;
   logic              w_req_fire;
   logic              w_resp_drop;
   logic              w_resp_push;
   logic              w_pop;
   logic [CNT_W-1:0]  w_resp_dec;
   logic [2*XLEN-1:0] w_head_raw;
   fetch_entry_t      w_head;
   fetch_entry_t      w_push_entry;

   // Buffered plus in-flight (stale included) never exceeds DEPTH, so every response has a slot.
   assign w_in_use         = {1'b0, w_occupancy} + {1'b0, r_outstanding};
   assign o_imem_req_valid = !i_reset && !i_redirect_valid && (r_drop_cnt == '0)
                             && !w_full && (w_in_use < C_DEPTH);
   assign o_imem_req_addr  = r_fetch_pc;

   assign w_req_fire   = o_imem_req_valid && i_imem_req_ready;
   assign w_resp_drop  = i_imem_resp_valid && (r_drop_cnt != '0);
   assign w_resp_push  = i_imem_resp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
   assign w_resp_dec   = CNT_W'(i_imem_resp_valid);
   assign w_pop        = o_out_valid && i_out_ready;
   assign w_push_entry = '{pc: r_resp_pc, inst: i_imem_resp_data};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (i_redirect_valid) begin
         // Everything still in flight is stale; a response arriving now is discarded too.
         r_fetch_pc    <= align_word(i_redirect_pc);
         r_resp_pc     <= align_word(i_redirect_pc);
         r_outstanding <= r_outstanding - w_resp_dec;
         r_drop_cnt    <= r_outstanding - w_resp_dec;
      end else begin
         if (w_req_fire)  r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_resp_push) r_resp_pc  <= r_resp_pc + 32'd4;
         r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - w_resp_dec;
         if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
   end

   ifu_inst_fifo #(
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_push      (w_resp_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .i_flush     (i_redirect_valid),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_occupancy),
      .o_head      (w_head_raw)
   );

   // Outputs come only from registered FIFO state; an empty buffer presents zeros.
   assign w_head      = fetch_entry_t'(w_head_raw);
   assign o_out_valid = !w_empty;
   assign o_out_pc    = w_empty ? 32'd0 : w_head.pc;
   assign o_out_inst  = w_empty ? 32'd0 : w_head.inst;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Scoreboard bench for ifu_fetch_buffer with a latency-configurable memory model.
module tb_ifu_fetch_buffer;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          DEPTH    = 4;

   logic        i_clk;
   logic        i_reset;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_resp_valid;
   logic [31:0] i_imem_resp_data;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_out_pc;
   logic [31:0] o_out_inst;
   logic        i_redirect_valid;
   logic [31:0] i_redirect_pc;

   ifu_fetch_buffer #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .o_imem_req_valid  (o_imem_req_valid),
      .i_imem_req_ready  (i_imem_req_ready),
      .o_imem_req_addr   (o_imem_req_addr),
      .i_imem_resp_valid (i_imem_resp_valid),
      .i_imem_resp_data  (i_imem_resp_data),
      .o_out_valid       (o_out_valid),
      .i_out_ready       (i_out_ready),
      .o_out_pc          (o_out_pc),
      .o_out_inst        (o_out_inst),
      .i_redirect_valid  (i_redirect_valid),
      .i_redirect_pc     (i_redirect_pc)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      int          due;
      logic [31:0] addr;
      bit          stale;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   mreq_t       mem_q[$];
   exp_t        exp_q[$];
   logic [31:0] req_log[$];
   logic [31:0] m_pc;
   int          checks, failures;
   int          cyc, lat, rr_mode, or_mode, resp_pct;
   int          hs_cnt, req_cnt, first_hs, first_new_req, wrap_seen, base;
   bit          chk_ov0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: observes handshakes each cycle and scores them against the reference queue.
   always @(negedge i_clk) begin
      exp_t e;
      int   sn;
      if (!i_reset) begin
         if (chk_ov0) begin
            check("out_valid_after_redirect", 32'(o_out_valid), 32'd0);
            chk_ov0 = 1'b0;
         end
         if (o_out_valid && i_out_ready) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_out_pc", o_out_pc, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               check("out_pc", o_out_pc, e.pc);
               check("out_inst", o_out_inst, e.inst);
            end
         end
         if (i_redirect_valid) begin
            check("req_in_redirect", 32'(o_imem_req_valid), 32'd0);
            exp_q.delete();
            m_pc = i_redirect_pc & ~32'h3;
            chk_ov0 = 1'b1;
            first_new_req = -1;
            foreach (mem_q[k]) mem_q[k].stale = 1'b1;
         end
         if (o_imem_req_valid && i_imem_req_ready) begin
            sn = 0;
            foreach (mem_q[k]) if (mem_q[k].stale) sn++;
            check("req_addr", o_imem_req_addr, m_pc);
            check("req_while_stale", 32'(sn), 32'd0);
            check("credit", 32'(exp_q.size() < DEPTH), 32'd1);
            if (o_imem_req_addr == 32'd0) wrap_seen++;
            exp_q.push_back('{pc: m_pc, inst: memfn(m_pc)});
            mem_q.push_back('{due: cyc + lat, addr: o_imem_req_addr, stale: 1'b0});
            req_log.push_back(o_imem_req_addr);
            m_pc = m_pc + 32'd4;
            req_cnt++;
            if (first_new_req < 0) first_new_req = cyc;
         end
      end
   end

   task automatic cycle_drive(input bit rdr, input logic [31:0] rpc);
      mreq_t m;
      @(posedge i_clk);
      cyc++;
      #1;
      i_reset           = 1'b0;
      i_imem_resp_valid = 1'b0;
      i_imem_resp_data  = 32'd0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < resp_pct) begin
         m = mem_q.pop_front();
         i_imem_resp_valid = 1'b1;
         i_imem_resp_data  = memfn(m.addr);
      end
      case (rr_mode)
         0:       i_imem_req_ready = 1'b1;
         1:       i_imem_req_ready = ($urandom_range(3) != 0);
         2:       i_imem_req_ready = cyc[0];
         default: i_imem_req_ready = 1'b0;
      endcase
      case (or_mode)
         0:       i_out_ready = 1'b1;
         1:       i_out_ready = 1'b0;
         default: i_out_ready = ($urandom_range(9) < 7);
      endcase
      i_redirect_valid = rdr;
      i_redirect_pc    = rpc;
      @(negedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      cyc++;
      #1;
      i_reset           = 1'b1;
      i_imem_req_ready  = 1'b0;
      i_imem_resp_valid = 1'b0;
      i_imem_resp_data  = 32'd0;
      i_out_ready       = 1'b0;
      i_redirect_valid  = 1'b0;
      i_redirect_pc     = 32'd0;
      mem_q.delete();
      exp_q.delete();
      req_log.delete();
      m_pc = RESET_PC;
      chk_ov0 = 1'b0;
      hs_cnt = 0; req_cnt = 0; first_hs = -1; first_new_req = -1; wrap_seen = 0;
      @(posedge i_clk);
      cyc++;
      #1;
      check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
      check("rst_req_addr", o_imem_req_addr, RESET_PC);
      check("rst_out_valid", 32'(o_out_valid), 32'd0);
      check("rst_out_pc", o_out_pc, 32'd0);
      check("rst_out_inst", o_out_inst, 32'd0);
      base = cyc + 1;
   endtask

   initial begin
      logic [31:0] tgt;
      int          idx;
      checks = 0; failures = 0; cyc = 0;
      lat = 1; rr_mode = 0; or_mode = 0; resp_pct = 100;
      i_reset = 1'b1; i_imem_req_ready = 1'b0; i_imem_resp_valid = 1'b0;
      i_imem_resp_data = 32'd0; i_out_ready = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = 32'd0;

      // Streaming at L=1 with the core always ready.
      do_reset();
      repeat (40) cycle_drive(1'b0, 32'd0);
      check("first_out_latency", 32'(first_hs - base), 32'd2);
      check("throughput", 32'(hs_cnt), 32'd38);

      // Core stalled: credit fills the buffer, then releases.
      or_mode = 1;
      do_reset();
      repeat (20) cycle_drive(1'b0, 32'd0);
      check("stall_req_count", 32'(req_cnt), 32'd4);
      check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
      check("stall_out_valid", 32'(o_out_valid), 32'd1);
      or_mode = 0;
      hs_cnt = 0;
      repeat (4) cycle_drive(1'b0, 32'd0);
      check("release_pops", 32'(hs_cnt), 32'd4);
      repeat (10) cycle_drive(1'b0, 32'd0);
      check("resume_addr", (req_log.size() > 4) ? req_log[4] : 32'd0, 32'h8000_0010);

      // Memory ready toggling every cycle.
      rr_mode = 2;
      do_reset();
      repeat (40) cycle_drive(1'b0, 32'd0);
      check("toggle_req_count", 32'(req_cnt >= 15), 32'd1);

      // Redirect with two stale reads in flight at L=3.
      rr_mode = 0; lat = 3;
      do_reset();
      repeat (2) cycle_drive(1'b0, 32'd0);
      cycle_drive(1'b1, 32'h8000_0101);
      repeat (12) cycle_drive(1'b0, 32'd0);
      check("stale_first_req_cycle", 32'(first_new_req - base), 32'd5);
      check("stale_first_req_addr", (req_log.size() > 2) ? req_log[2] : 32'd0, 32'h8000_0100);

      // Redirect coincident with a response and an out handshake.
      lat = 1;
      do_reset();
      repeat (2) cycle_drive(1'b0, 32'd0);
      cycle_drive(1'b1, 32'h8000_0200);
      check("coincident_hs", 32'(hs_cnt), 32'd1);
      repeat (10) cycle_drive(1'b0, 32'd0);
      check("coincident_new_addr", (req_log.size() > 2) ? req_log[2] : 32'd0, 32'h8000_0200);

      // Fetch PC wrap past the top of the address space.
      lat = 2;
      do_reset();
      repeat (3) cycle_drive(1'b0, 32'd0);
      cycle_drive(1'b1, 32'hFFFF_FFF8);
      repeat (10) cycle_drive(1'b0, 32'd0);
      check("wrap_seen", 32'(wrap_seen), 32'd1);

      // Randomised traffic with latency changes, redirects and a mid-run reset.
      rr_mode = 1; or_mode = 2; resp_pct = 80;
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         lat = $urandom_range(3, 1);
         if (blk == 7) do_reset();
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(99) < 3) begin
               idx = $urandom_range(2);
               if (idx == 0)      tgt = $urandom;
               else if (idx == 1) tgt = 32'hFFFF_FFE0 | 32'($urandom_range(31));
               else               tgt = RESET_PC + 32'($urandom_range(255));
               cycle_drive(1'b1, tgt);
            end else begin
               cycle_drive(1'b0, 32'd0);
            end
         end
      end

      // Stop issuing and let everything drain.
      rr_mode = 3; or_mode = 0; resp_pct = 100;
      for (int c = 0; c < 100 && (exp_q.size() != 0 || mem_q.size() != 0); c++)
         cycle_drive(1'b0, 32'd0);
      cycle_drive(1'b0, 32'd0);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_out_valid", 32'(o_out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
